serial_add_unit: RTL and testbench
==================================

Name: serial_add_unit

Overview:
- Bit-serial adder, the add-direction counterpart of the team's half-subtractor arithmetic.
- Adds two WIDTH-bit operands plus a carry-in, LSB-first, one bit per clock, through a single registered full-adder stage.
- Start/busy/done handshake, so a controller can issue back-to-back additions with minimal area.
- Sum and carry-out are held stable until the next accepted operation.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal: >= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- cin  input  1  carry-in; captured on the accepted start edge.
- busy  output  1  high while a bit-serial addition is in progress.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  registered result, (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered carry-out of bit WIDTH-1.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry flop and bit counter cleared.
- Reset mid-operation: the addition is aborted and no done pulse is produced; sum/cout read 0.
- States: IDLE, ADD, DONE.
- IDLE:
  - busy=0, done=0.
  - On the edge where start=1: load opA<=a, opB<=b, carry<=cin, cnt<=0, go to ADD.
- ADD (busy=1), each edge:
  - s = opA[0] ^ opB[0] ^ carry
  - carry <= (opA[0] & opB[0]) | (carry & (opA[0] ^ opB[0]))
  - opA, opB shift right by 1, zero fill.
  - Working result register shifts right with s inserted at the MSB.
  - cnt increments.
  - On the edge processing bit WIDTH-1 (cnt==WIDTH-1):
    - Copy the final working result to sum and the final carry to cout.
    - done<=1, busy<=0, go to DONE.
- DONE:
  - Lasts exactly one cycle with done=1; next edge: done<=0, go to IDLE.
- Latency:
  - Start accepted at edge E0. Bits are processed at edges E1..E_WIDTH.
  - done goes high after edge E_WIDTH and low after E_WIDTH+1.
  - busy is high from after E0 until after E_WIDTH.
  - Earliest next accepted start is at edge E_WIDTH+2 (first IDLE edge).
- start while in ADD or DONE is ignored; no queuing.
- sum/cout:
  - Change only at the completion edge; they hold the previous result during ADD.
  - They hold the new result indefinitely while IDLE.
- Inputs a/b/cin may change freely after the accepting edge without affecting the result.
- Arithmetic: full WIDTH+1-bit result {cout,sum} = a + b + cin, unsigned, no saturation.
  - Wrap-around is reported only via cout.

Test Plan:
- Reset, then WIDTH=8, a=0x3C, b=0x0F, cin=0, start one cycle → done exactly 8 edges after the accept edge; sum=0x4B, cout=0; busy high for exactly 8 cycles.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0x5A, b=0xA5, cin=1 → sum=0x00, cout=1. Then a=0x00, b=0x00, cin=0 → sum=0x00, cout=0.
- Start held high continuously with a=0x10, b=0x20, cin=0 and operands changed to 0xFF during ADD → first result sum=0x30, cout=0; the next operation is accepted only at the first IDLE edge, and extra start pulses in ADD/DONE are ignored.
- Previous result sum=0x4B; launch a new add of 0x80+0x80 → sum stays 0x4B throughout ADD, then becomes 0x00 with cout=1 together with done.
- Assert rst_n=0 asynchronously at the 4th ADD cycle → busy, done, sum and cout go to 0 immediately without a clock edge; no done pulse follows; the next start after release completes normally (0x01+0x01 → 0x02).
- Randomised sweep of 256 operand pairs with random cin against a reference model → {cout,sum} matches a+b+cin on every done pulse.

Source files
------------

// File: rtl/serial_add_unit.sv
// Bit-serial adder: one full-adder stage processes a, b, cin LSB-first, one bit per clock.
// sum/cout update only on the completion edge and hold until the next accepted operation.
module serial_add_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] work;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s;
    logic             carry_nx;
    logic [WIDTH-1:0] work_nx;

    always_comb begin
        s        = op_a[0] ^ op_b[0] ^ carry;
        carry_nx = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
        work_nx  = {s, work[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            work  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
                    end
                end
                ADD: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    work  <= work_nx;
                    carry <= carry_nx;
                    cnt   <= cnt + 1'b1;
                    // Last bit: publish the result straight from the adder stage.
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= work_nx;
                        cout  <= carry_nx;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_unit.sv
// Directed bench for serial_add_unit (WIDTH=8): latency, handshake, result hold,
// async abort and an operand sweep against a+b+cin.
module tb_serial_add_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int total = 0;
    int bad = 0;

    serial_add_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    // Accept at the next posedge, scramble inputs, wait for done; leaves bench in IDLE.
    task automatic do_add(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                          output int lat, output int busy_cyc, output logic ok);
        a = ia; b = ib; cin = ic; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = 8'hFF; b = 8'hFF; cin = 1'b1;
        lat = 0; busy_cyc = 0; ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) begin lat = k; ok = 1'b1; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_res(input string name, input logic ok, input logic [8:0] exp);
        total++;
        if (!ok || {cout, sum} !== exp) begin
            bad++;
            $display("FAIL %s: got ok=%0b {cout,sum}=%h, want %h", name, ok, {cout, sum}, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, cout, sum} !== 11'd0) begin
            bad++;
            $display("FAIL reset_state: got busy=%0b done=%0b cout=%0b sum=%h, want all 0", busy, done, cout, sum);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, bc; logic ok;
        do_add(8'h3C, 8'h0F, 1'b0, lat, bc, ok);
        check_res("basic_3c_0f", ok, 9'h04B);
        total++;
        if (lat !== 8) begin bad++; $display("FAIL basic_latency: got %0d, want 8", lat); end
        total++;
        if (bc !== 8) begin bad++; $display("FAIL basic_busy_cycles: got %0d, want 8", bc); end
    endtask

    task automatic test_carry();
        int lat, bc; logic ok;
        do_add(8'hFF, 8'h01, 1'b0, lat, bc, ok);
        check_res("ff_plus_01", ok, 9'h100);
        do_add(8'h5A, 8'hA5, 1'b1, lat, bc, ok);
        check_res("5a_a5_cin", ok, 9'h100);
        do_add(8'h00, 8'h00, 1'b0, lat, bc, ok);
        check_res("zero_zero", ok, 9'h000);
    endtask

    task automatic test_start_held();
        int lat; logic ok;
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 8'hFF; b = 8'hFF;
        ok = 1'b0; lat = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin lat = k; ok = 1'b1; break; end
        end
        check_res("held_first", ok, 9'h030);
        total++;
        if (lat !== 8) begin bad++; $display("FAIL held_latency: got %0d, want 8", lat); end
        @(negedge clk);  // after DONE edge: start ignored there
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL held_idle_gap: got busy=%0b done=%0b, want 0 0", busy, done);
        end
        @(negedge clk);  // after first IDLE edge: accepted
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL held_reaccept: got busy=%0b, want 1", busy); end
        start = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        check_res("held_second", ok, 9'h1FE);
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        int lat, bc; logic ok; int held_bad;
        do_add(8'h3C, 8'h0F, 1'b0, lat, bc, ok);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ok = 1'b0; held_bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
            if (sum !== 8'h4B || cout !== 1'b0) held_bad++;
        end
        total++;
        if (held_bad != 0) begin
            bad++; $display("FAIL hold_during_add: %0d cycles changed, want 0", held_bad);
        end
        check_res("hold_new_result", ok, 9'h100);
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int lat, bc; logic ok; int dones;
        do_add(8'h3C, 8'h0F, 1'b0, lat, bc, ok);
        a = 8'h11; b = 8'h22; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, cout, sum} !== 11'd0) begin
            bad++;
            $display("FAIL abort_async: got busy=%0b done=%0b cout=%0b sum=%h, want all 0", busy, done, cout, sum);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        total++;
        if (dones != 0) begin bad++; $display("FAIL abort_no_done: got %0d active cycles, want 0", dones); end
        @(posedge clk); #1;
        do_add(8'h01, 8'h01, 1'b0, lat, bc, ok);
        check_res("after_abort", ok, 9'h002);
    endtask

    task automatic test_sweep();
        int lat, bc; logic ok;
        logic [7:0] ra, rb; logic rc; logic [8:0] exp;
        for (int i = 0; i < 256; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            exp = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            do_add(ra, rb, rc, lat, bc, ok);
            total++;
            if (!ok || {cout, sum} !== exp) begin
                bad++;
                $display("FAIL sweep %h+%h+%0b: got %h, want %h", ra, rb, rc, {cout, sum}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_start_held();
        test_hold();
        test_abort();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
